// File: rtl/mm_ctrl_pkg.sv
// mm_ctrl_pkg: shared constants, state encoding and step codes for the matrix multiplier control
package mm_ctrl_pkg;
  localparam int NUM_STEPS = 13;
  localparam int CODE_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;
  localparam logic [CODE_W-1:0] STEP_NONE = 4'd0;
  localparam logic [CODE_W-1:0] STEP_1 = 4'd1;
  localparam logic [CODE_W-1:0] STEP_2 = 4'd2;
  localparam logic [CODE_W-1:0] STEP_3 = 4'd3;
  localparam logic [CODE_W-1:0] STEP_4 = 4'd4;
  localparam logic [CODE_W-1:0] STEP_5 = 4'd5;
  localparam logic [CODE_W-1:0] STEP_6 = 4'd6;
  localparam logic [CODE_W-1:0] STEP_7 = 4'd7;
  localparam logic [CODE_W-1:0] STEP_8 = 4'd8;
  localparam logic [CODE_W-1:0] STEP_9 = 4'd9;
  localparam logic [CODE_W-1:0] STEP_10 = 4'd10;
  localparam logic [CODE_W-1:0] STEP_11 = 4'd11;
  localparam logic [CODE_W-1:0] STEP_12 = 4'd12;
  localparam logic [CODE_W-1:0] STEP_13 = 4'd13;
endpackage

// File: rtl/mm_step_sequencer.sv
// mm_step_sequencer: issues step codes 1..NUM_STEPS per round, one per ack, for the step decoder
module mm_step_sequencer #(
  parameter int NUM_STEPS = mm_ctrl_pkg::NUM_STEPS,
  parameter int CODE_W = mm_ctrl_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] rounds,
  input  logic              step_ack,
  input  logic              abort,
  output logic [CODE_W-1:0] step_code,
  output logic              step_valid,
  output logic [CODE_W-1:0] round_idx,
  output logic              busy,
  output logic              done
);
  import mm_ctrl_pkg::*;
  localparam logic [CODE_W-1:0] LAST = CODE_W'(NUM_STEPS);
  localparam logic [CODE_W-1:0] FIRST = CODE_W'(STEP_1);
  state_e st_q, st_d;
  logic [CODE_W-1:0] code_q, code_d, round_q, round_d, rounds_q, rounds_d;
  logic valid_q, busy_q, done_q, wrap, more;
  assign wrap = code_q == LAST;
  assign more = round_q != rounds_q - 1'b1;
  always_comb begin
    st_d = st_q;
    code_d = code_q;
    round_d = round_q;
    rounds_d = rounds_q;
    if (abort) begin
      st_d = IDLE;
      code_d = '0;
    end else if (st_q == IDLE && start) begin
      rounds_d = rounds;
      round_d = '0;
      st_d = rounds != '0 ? ISSUE : DONE;
      code_d = rounds != '0 ? FIRST : '0;
    end else if (st_q == ISSUE && step_ack) begin
      code_d = !wrap ? code_q + 1'b1 : more ? FIRST : '0;
      round_d = wrap && more ? round_q + 1'b1 : round_q;
      st_d = wrap && !more ? DONE : ISSUE;
    end else if (st_q == DONE) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      code_q <= '0;
      round_q <= '0;
      rounds_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      code_q <= code_d;
      round_q <= round_d;
      rounds_q <= rounds_d;
      valid_q <= code_d != '0;
      busy_q <= st_d != IDLE;
      done_q <= st_d == DONE;
    end
  end
  assign step_code = code_q;
  assign step_valid = valid_q;
  assign round_idx = round_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_mm_step_sequencer.sv
// tb_mm_step_sequencer: directed scoreboard bench for the step sequencer
module tb_mm_step_sequencer;
  typedef struct packed {
    logic [3:0] code;
    logic       valid;
    logic [3:0] round;
    logic       busy;
    logic       done;
  } obs_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, step_ack = 1'b0, abort = 1'b0;
  logic [3:0] rounds = 4'd0;
  logic [3:0] step_code, round_idx;
  logic step_valid, busy, done;
  obs_t sb[$];
  int checks = 0, fails = 0;
  mm_step_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .rounds(rounds), .step_ack(step_ack), .abort(abort),
    .step_code(step_code), .step_valid(step_valid), .round_idx(round_idx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic push(input int c, input int r, input logic b, input logic d);
    obs_t e;
    e.code = 4'(c);
    e.valid = c != 0;
    e.round = 4'(r);
    e.busy = b;
    e.done = d;
    sb.push_back(e);
  endtask
  task automatic tick(input string tag);
    obs_t o, e;
    @(posedge clk);
    #1;
    o = '{step_code, step_valid, round_idx, busy, done};
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        fails++;
        $error("FAIL %s: observed code=%0d v=%0d r=%0d b=%0d d=%0d expected code=%0d v=%0d r=%0d b=%0d d=%0d",
               tag, o.code, o.valid, o.round, o.busy, o.done, e.code, e.valid, e.round, e.busy, e.done);
      end
    end
  endtask
  task automatic run_acked(input int n, input string tag);
    start = 1'b1;
    rounds = 4'(n);
    step_ack = 1'b1;
    push(1, 0, 1, 0);
    tick(tag);
    start = 1'b0;
    for (int i = 1; i < n * 13; i++) begin
      push(i % 13 + 1, i / 13, 1, 0);
      tick(tag);
    end
    push(0, n - 1, 1, 1);
    tick({tag, "_done"});
    push(0, n - 1, 0, 0);
    tick({tag, "_idle"});
    step_ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end
  initial begin
    @(posedge clk);
    #1;
    rst = 1'b1;
    push(0, 0, 0, 0);
    tick("reset");
    rst = 1'b0;
    push(0, 0, 0, 0);
    tick("idle");
    run_acked(1, "r1");
    run_acked(3, "r3");
    start = 1'b1;
    rounds = 4'd2;
    push(1, 0, 1, 0);
    tick("slow_start");
    for (int i = 0; i < 26; i++) begin
      for (int j = 0; j < 3; j++) begin
        step_ack = j == 2;
        start = j == 0 && i % 4 == 1;
        rounds = 4'd5;
        if (j < 2) push(i % 13 + 1, i / 13, 1, 0);
        else if (i == 25) push(0, 1, 1, 1);
        else push((i + 1) % 13 + 1, (i + 1) / 13, 1, 0);
        tick("slow");
      end
    end
    start = 1'b0;
    step_ack = 1'b0;
    push(0, 1, 0, 0);
    tick("slow_idle");
    start = 1'b1;
    rounds = 4'd0;
    push(0, 0, 1, 1);
    tick("zero_done");
    rounds = 4'd1;
    push(0, 0, 0, 0);
    tick("start_in_done");
    push(1, 0, 1, 0);
    tick("restart");
    start = 1'b0;
    abort = 1'b1;
    push(0, 0, 0, 0);
    tick("abort_early");
    abort = 1'b0;
    start = 1'b1;
    rounds = 4'd2;
    step_ack = 1'b1;
    push(1, 0, 1, 0);
    tick("ab_run");
    start = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      push(i % 13 + 1, i / 13, 1, 0);
      tick("ab_run");
    end
    abort = 1'b1;
    push(0, 1, 0, 0);
    tick("abort");
    abort = 1'b0;
    step_ack = 1'b0;
    push(0, 1, 0, 0);
    tick("abort_nodone");
    start = 1'b1;
    push(1, 0, 1, 0);
    tick("abort_restart");
    start = 1'b0;
    step_ack = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      push(i % 13 + 1, i / 13, 1, 0);
      tick("rst_run");
    end
    rst = 1'b1;
    push(0, 0, 0, 0);
    tick("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 0, 0);
      tick("ack_idle");
    end
    step_ack = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
